// File: rtl/regfl_mp_if.sv
// rtl/regfl_mp_if.sv - write/read/clear bus of the regfl_mp register file
interface regfl_mp_if #(
    parameter int W = 64,
    parameter int N = 8
);
    localparam int AW = $clog2(N);
    localparam int BW = W / 8;

    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [BW-1:0] wbe;
    logic [AW-1:0] ra0;
    logic [AW-1:0] ra1;
    logic [W-1:0]  rd0;
    logic [W-1:0]  rd1;
    logic          clr_req;
    logic          busy;
    logic [N-1:0]  vld;
    logic [N*W-1:0] q;

    modport master (
        output we, wa, wd, wbe, ra0, ra1, clr_req,
        input  rd0, rd1, busy, vld, q
    );

    modport slave (
        input  we, wa, wd, wbe, ra0, ra1, clr_req,
        output rd0, rd1, busy, vld, q
    );
endinterface

// File: rtl/regfl_mp.sv
// rtl/regfl_mp.sv - byte-enabled 2R1W register file with bypass, valid bitmap and clear-all engine
module regfl_mp #(
    parameter int W = 64,
    parameter int N = 8
) (
    input logic       clk,
    input logic       rst,
    regfl_mp_if.slave bus
);
    localparam int AW = $clog2(N);
    localparam int BW = W / 8;

    typedef enum logic {IDLE, CLR} state_t;

    state_t        state;
    logic [AW-1:0] ptr;
    logic [W-1:0]  mem [N];
    logic [N-1:0]  vld_r;
    logic [W-1:0]  rd0_r;
    logic [W-1:0]  rd1_r;
    logic          busy_r;
    logic          wr_ok;
    logic [W-1:0]  merged;
    logic [W-1:0]  nxt0;
    logic [W-1:0]  nxt1;

    assign wr_ok = bus.we && !busy_r;

    always_comb begin
        merged = mem[bus.wa];
        for (int k = 0; k < BW; k++) begin
            if (bus.wbe[k]) merged[8*k +: 8] = bus.wd[8*k +: 8];
        end
    end

    // Reads see the post-edge word: a clear on the same edge wins, then a same-edge write.
    always_comb begin
        nxt0 = mem[bus.ra0];
        nxt1 = mem[bus.ra1];
        if (state == CLR && bus.ra0 == ptr)   nxt0 = '0;
        else if (wr_ok && bus.ra0 == bus.wa)  nxt0 = merged;
        if (state == CLR && bus.ra1 == ptr)   nxt1 = '0;
        else if (wr_ok && bus.ra1 == bus.wa)  nxt1 = merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
            vld_r  <= '0;
            rd0_r  <= '0;
            rd1_r  <= '0;
            busy_r <= 1'b0;
            state  <= IDLE;
            ptr    <= '0;
        end else begin
            rd0_r <= nxt0;
            rd1_r <= nxt1;
            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        mem[bus.wa] <= merged;
                        if (|bus.wbe) vld_r[bus.wa] <= 1'b1;
                    end
                    if (bus.clr_req) begin
                        state  <= CLR;
                        busy_r <= 1'b1;
                        ptr    <= '0;
                    end
                end
                CLR: begin
                    mem[ptr]   <= '0;
                    vld_r[ptr] <= 1'b0;
                    ptr        <= ptr + 1'b1;
                    if (ptr == AW'(N - 1)) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // word0 occupies the most significant slice of the snapshot.
    always_comb begin
        bus.q = '0;
        for (int i = 0; i < N; i++) bus.q[(N-1-i)*W +: W] = mem[i];
    end

    assign bus.vld  = vld_r;
    assign bus.busy = busy_r;
    assign bus.rd0  = rd0_r;
    assign bus.rd1  = rd1_r;
endmodule
